rsa: RTL and testbench

256-bit RSA modular-exponentiation engine: computes C = M^E mod N on 256-bit operands. The three operands are loaded over a 32-bit word-serial input bus and the 256-bit result is returned over a 32-bit word-serial output bus. The same block serves for encryption (E = public exponent) and decryption (E = private exponent). It sits behind a simple enable-framed streaming interface driven by a host or controller.

---
 rtl/rsa.sv | 216 +++++++++++++++++++++
 tb/tb_rsa.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rsa.sv
// rsa: 256-bit modular exponentiation engine, C = M^E mod N.
// Operands arrive as 24 words on a 32-bit bus and the result leaves as 8 words, MSW first.
// Left-to-right square-and-multiply. The modular multiplier is radix-2 interleaved
// (shift-add, then up to two conditional subtracts of N), with two steps per clock.
module rsa (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] data,
    output logic [31:0] out,
    output logic        output_flag
);

    localparam int unsigned OP_W   = 256;
    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ACC_W  = OP_W + 2;
    localparam int unsigned SH_W   = 3 * OP_W;
    localparam int unsigned NWORDS = SH_W / BUS_W;
    localparam int unsigned OWORDS = OP_W / BUS_W;
    localparam int unsigned MSTEPS = OP_W / 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LOAD, S_COMPUTE, S_OUTPUT, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        PH_INIT, PH_SKIP, PH_SQR, PH_MUL, PH_NEXT, PH_FIN
    } phase_t;

    state_t             state_q;
    phase_t             phase_q;
    logic [SH_W-1:0]    sh_q;
    logic [OP_W-1:0]    r_q;
    logic [OP_W-1:0]    b_q;
    logic [ACC_W-1:0]   p_q;
    logic [4:0]         wcnt_q;
    logic [8:0]         ebits_q;
    logic [6:0]         mcnt_q;
    logic [2:0]         ocnt_q;
    logic [BUS_W-1:0]   out_q;
    logic               flag_q;

    logic [OP_W-1:0]    m_w;
    logic [OP_W-1:0]    e_w;
    logic [OP_W-1:0]    n_w;
    logic [ACC_W-1:0]   p1;
    logic [ACC_W-1:0]   p2;

    // Operand fields inside the load shift register; E is consumed in place MSB first
    assign m_w = sh_q[3*OP_W-1 -: OP_W];
    assign e_w = sh_q[2*OP_W-1 -: OP_W];
    assign n_w = sh_q[OP_W-1:0];

    assign out         = out_q;
    assign output_flag = flag_q;

    // One interleaved step: p stays below n because p, a < n implies 2p + a < 3n
    function automatic logic [ACC_W-1:0] mm_step(input logic [ACC_W-1:0] p,
                                                 input logic             bit_i,
                                                 input logic [OP_W-1:0]  a,
                                                 input logic [OP_W-1:0]  n);
        logic [ACC_W-1:0] t;
        logic [ACC_W-1:0] nn;
        nn = ACC_W'(n);
        t  = (p << 1) + (bit_i ? ACC_W'(a) : '0);
        if (t >= nn) t = t - nn;
        if (t >= nn) t = t - nn;
        return t;
    endfunction

    // Two multiplier steps per cycle; A is always the accumulator R
    always_comb begin
        p1 = mm_step(p_q, b_q[OP_W-1], r_q, n_w);
        p2 = mm_step(p1,  b_q[OP_W-2], r_q, n_w);
    end

    // Transaction FSM, exponentiation sequencer and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= PH_INIT;
            sh_q    <= '0;
            r_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            wcnt_q  <= '0;
            ebits_q <= '0;
            mcnt_q  <= '0;
            ocnt_q  <= '0;
            out_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_q  <= '0;
                    flag_q <= 1'b0;
                    if (enable) state_q <= S_START;
                end
                S_START: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else begin
                        wcnt_q  <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else begin
                        sh_q   <= {sh_q[SH_W-BUS_W-1:0], data};
                        wcnt_q <= wcnt_q + 5'd1;
                        if (wcnt_q == 5'(NWORDS - 1)) begin
                            phase_q <= PH_INIT;
                            state_q <= S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else begin
                        case (phase_q)
                            PH_INIT: begin
                                r_q     <= (n_w == OP_W'(1)) ? '0 : OP_W'(1);
                                ebits_q <= 9'(OP_W);
                                phase_q <= PH_SKIP;
                            end
                            // Leading zero bits of E only square R = 1, so skip them
                            PH_SKIP: begin
                                if (ebits_q == '0) begin
                                    phase_q <= PH_FIN;
                                end else if (!e_w[OP_W-1]) begin
                                    sh_q[2*OP_W-1 -: OP_W] <= {e_w[OP_W-2:0], 1'b0};
                                    ebits_q <= ebits_q - 9'd1;
                                end else begin
                                    b_q     <= r_q;
                                    p_q     <= '0;
                                    mcnt_q  <= '0;
                                    phase_q <= PH_SQR;
                                end
                            end
                            PH_SQR: begin
                                p_q    <= p2;
                                b_q    <= b_q << 2;
                                mcnt_q <= mcnt_q + 7'd1;
                                if (mcnt_q == 7'(MSTEPS - 1)) begin
                                    r_q <= p2[OP_W-1:0];
                                    if (e_w[OP_W-1]) begin
                                        b_q     <= m_w;
                                        p_q     <= '0;
                                        mcnt_q  <= '0;
                                        phase_q <= PH_MUL;
                                    end else begin
                                        phase_q <= PH_NEXT;
                                    end
                                end
                            end
                            PH_MUL: begin
                                p_q    <= p2;
                                b_q    <= b_q << 2;
                                mcnt_q <= mcnt_q + 7'd1;
                                if (mcnt_q == 7'(MSTEPS - 1)) begin
                                    r_q     <= p2[OP_W-1:0];
                                    phase_q <= PH_NEXT;
                                end
                            end
                            PH_NEXT: begin
                                sh_q[2*OP_W-1 -: OP_W] <= {e_w[OP_W-2:0], 1'b0};
                                ebits_q <= ebits_q - 9'd1;
                                if (ebits_q == 9'd1) begin
                                    phase_q <= PH_FIN;
                                end else begin
                                    b_q     <= r_q;
                                    p_q     <= '0;
                                    mcnt_q  <= '0;
                                    phase_q <= PH_SQR;
                                end
                            end
                            PH_FIN: begin
                                out_q   <= r_q[OP_W-1 -: BUS_W];
                                r_q     <= r_q << BUS_W;
                                flag_q  <= 1'b1;
                                ocnt_q  <= '0;
                                state_q <= S_OUTPUT;
                            end
                            default: phase_q <= PH_INIT;
                        endcase
                    end
                end
                S_OUTPUT: begin
                    if (!enable) begin
                        out_q   <= '0;
                        flag_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (ocnt_q == 3'(OWORDS - 1)) begin
                        out_q   <= '0;
                        flag_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        out_q  <= r_q[OP_W-1 -: BUS_W];
                        r_q    <= r_q << BUS_W;
                        ocnt_q <= ocnt_q + 3'd1;
                    end
                end
                S_DONE: begin
                    out_q  <= '0;
                    flag_q <= 1'b0;
                    if (!enable) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa.sv
// tb_rsa: directed vectors for the rsa modular-exponentiation engine.
module tb_rsa;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] data;
    logic [31:0] out;
    logic        output_flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [255:0] m;
        logic [255:0] e;
        logic [255:0] n;
        logic [255:0] c;
    } vec_t;

    rsa dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .data        (data),
        .out         (out),
        .output_flag (output_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something outside the bounded waits runs away
    initial begin
        #3000000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Raise enable, let the START cycle pass, then present nwords operand words
    task automatic load(input logic [255:0] m, input logic [255:0] e, input logic [255:0] n,
                        input int nwords);
        logic [767:0] ops;
        ops = {m, e, n};
        @(negedge clk);
        enable = 1'b1;
        data   = 32'hDEADBEEF;
        @(posedge clk);
        @(posedge clk);
        for (int k = 0; k < nwords; k++) begin
            @(negedge clk);
            data = ops[767 - 32*k -: 32];
            @(posedge clk);
        end
    endtask

    // Gather one output burst; returns when output_flag falls or the budget expires
    task automatic collect(input int budget, output logic [255:0] c, output int nflag,
                           output bit to, output int leak);
        c     = '0;
        nflag = 0;
        to    = 1'b1;
        leak  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            data = 32'hA5A5A5A5;
            if (output_flag) begin
                c = {c[223:0], out};
                nflag++;
            end else begin
                if (out !== 32'h0) leak++;
                if (nflag > 0) begin
                    to = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic count_flag(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (output_flag !== 1'b0) n++;
        end
    endtask

    task automatic run_full(input string name, input logic [255:0] m, input logic [255:0] e,
                            input logic [255:0] n, input logic [255:0] exp);
        logic [255:0] c;
        int           nf;
        int           leak;
        bit           to;
        load(m, e, n, 24);
        collect(70000, c, nf, to, leak);
        check({name, "_timeout"}, 256'(to), 256'd0);
        check({name, "_result"}, c, exp);
        check({name, "_burst_len"}, 256'(nf), 256'd8);
        check({name, "_out_zero"}, 256'(leak), 256'd0);
    endtask

    initial begin
        logic [255:0] p;
        logic [255:0] d;
        logic [255:0] pt;
        logic [255:0] ct;
        logic [255:0] c;
        logic [257:0] t;
        int           nf;
        int           leak;
        bit           to;
        vec_t         tv[12];

        rst_n  = 1'b0;
        enable = 1'b0;
        data   = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_out", 256'(out), 256'd0);
        check("reset_flag", 256'(output_flag), 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Prime modulus 2^255-19 with e = 5, d = (3(p-1)+1)/5 so that e*d = 1 mod (p-1)
        p  = (256'd1 << 255) - 256'd19;
        t  = (258'd3 << 255) - 258'd59;
        d  = 256'(t / 258'd5);
        pt = "RSA-256 passed congragulations:)";

        tv[0]  = '{256'd2, 256'd10, 256'd1000, 256'd24};
        tv[1]  = '{256'd5, 256'd0, 256'd7, 256'd1};
        tv[2]  = '{256'd0, 256'd3, 256'd7, 256'd0};
        tv[3]  = '{256'd0, 256'd5, 256'd1, 256'd0};
        tv[4]  = '{256'd0, 256'd0, 256'd1, 256'd0};
        tv[5]  = '{256'd7, 256'd13, 256'd11, 256'd2};
        tv[6]  = '{256'd3, 256'd4, 256'd100, 256'd81};
        tv[7]  = '{256'd1 << 200, 256'd1, p, 256'd1 << 200};
        tv[8]  = '{p - 256'd1, 256'd2, p, 256'd1};
        tv[9]  = '{p - 256'd1, 256'd3, p, p - 256'd1};
        tv[10] = '{256'd2, 256'd255, p, 256'd19};
        tv[11] = '{256'd2, 256'd256, p, 256'd38};

        for (int i = 0; i < 12; i++) begin
            run_full($sformatf("vec%0d", i), tv[i].m, tv[i].e, tv[i].n, tv[i].c);
            enable = 1'b0;
            @(negedge clk);
        end

        // Round trip: encrypt with e, idle four cycles, decrypt with d
        load(pt, 256'd5, p, 24);
        collect(70000, ct, nf, to, leak);
        check("rt_enc_timeout", 256'(to), 256'd0);
        check("rt_enc_burst_len", 256'(nf), 256'd8);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        load(ct, d, p, 24);
        collect(70000, c, nf, to, leak);
        check("rt_dec_timeout", 256'(to), 256'd0);
        check("rt_plaintext", c, pt);
        enable = 1'b0;
        @(negedge clk);

        // Abort after ten loaded words, then a clean transaction
        load(256'd3, 256'd4, 256'd100, 10);
        @(negedge clk);
        enable = 1'b0;
        count_flag(40, nf);
        check("abort_no_flag", 256'(nf), 256'd0);
        check("abort_out", 256'(out), 256'd0);
        run_full("after_abort", 256'd3, 256'd4, 256'd100, 256'd81);
        enable = 1'b0;
        @(negedge clk);

        // Reset while computing 2^255 mod p
        load(256'd2, 256'd255, p, 24);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b0;
        check("midreset_out", 256'(out), 256'd0);
        check("midreset_flag", 256'(output_flag), 256'd0);
        count_flag(3000, nf);
        check("midreset_no_flag", 256'(nf), 256'd0);
        run_full("after_reset", 256'd7, 256'd13, 256'd11, 256'd2);

        // Enable held high after the burst must not produce a second one
        enable = 1'b0;
        @(negedge clk);
        run_full("hold", 256'd2, 256'd10, 256'd1000, 256'd24);
        count_flag(20, nf);
        check("hold_no_second_burst", 256'(nf), 256'd0);
        enable = 1'b0;
        @(negedge clk);
        run_full("after_hold", 256'd3, 256'd4, 256'd100, 256'd81);
        enable = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
